// File: rtl/cart_mapper.sv
// 2600-style cartridge bank mapper: 2K/4K/F8/F6/F4 hotspot banking
// with optional Superchip 128-byte RAM and a 1-clk registered read path.
module cart_mapper #(
  parameter int MAX_BANKS = 8,
  parameter bit SC_EN     = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic [12:0]                     adr_i,
  input  logic                            we_i,
  input  logic [7:0]                      dat_i,
  output logic [7:0]                      dat_o,
  input  logic [2:0]                      mode_i,
  input  logic                            sc_i,
  output logic [12+$clog2(MAX_BANKS)-1:0] rom_adr_o,
  input  logic [7:0]                      rom_dat_i,
  output logic [2:0]                      bank_o
);

  localparam int AW = 12 + $clog2(MAX_BANKS);
  localparam logic [2:0] MAXM = 3'(MAX_BANKS - 1);

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_ROM,
    SEL_RAM
  } sel_e;

  // Bank mask doubles as the start bank: the last effective bank.
  function automatic logic [2:0] mode_mask(input logic [2:0] m);
    logic [2:0] r;
    case (m)
      3'd2:    r = 3'b001;
      3'd3:    r = 3'b011;
      3'd4:    r = 3'b111;
      default: r = 3'b000;
    endcase
    return r & MAXM;
  endfunction

  logic [2:0]  mode_q;
  logic        mchg_q;
  logic [2:0]  bank_q;
  logic [2:0]  bank_d;
  sel_e        sel_q;
  sel_e        sel_d;
  logic [7:0]  ram_q [128];
  logic [7:0]  ram_rd_q;

  logic [11:0] off;
  logic        cart;
  logic        hot_en;
  logic [11:0] hot_lo;
  logic [11:0] hot_hi;
  logic        hot_hit;
  logic [2:0]  hot_bank;
  logic        sc_on;
  logic        sc_wr_hit;
  logic        sc_rd_hit;
  logic        ram_we;
  logic [14:0] rom_full;

  assign off  = adr_i[11:0];
  assign cart = adr_i[12];

  always_comb begin
    hot_en = 1'b1;
    hot_lo = 12'hFF8;
    hot_hi = 12'hFF9;
    case (mode_q)
      3'd2: begin
        hot_lo = 12'hFF8;
        hot_hi = 12'hFF9;
      end
      3'd3: begin
        hot_lo = 12'hFF6;
        hot_hi = 12'hFF9;
      end
      3'd4: begin
        hot_lo = 12'hFF4;
        hot_hi = 12'hFFB;
      end
      default: hot_en = 1'b0;
    endcase
  end

  assign hot_hit = enable_i & cart & hot_en &
                   (off >= hot_lo) & (off <= hot_hi);
  // Ranges span at most 8 slots, so modulo-8 subtraction is exact.
  assign hot_bank = (off[2:0] - hot_lo[2:0]) & mode_mask(mode_q);

  always_comb begin
    bank_d = bank_q;
    if (mchg_q)
      bank_d = mode_mask(mode_q);
    else if (hot_hit)
      bank_d = hot_bank;
  end

  assign sc_on     = SC_EN & sc_i;
  assign sc_wr_hit = cart & sc_on & (off[11:7] == 5'd0);
  assign sc_rd_hit = cart & sc_on & (off[11:7] == 5'd1);
  assign ram_we    = enable_i & we_i & sc_wr_hit;

  always_comb begin
    sel_d = SEL_ROM;
    if (!cart)
      sel_d = SEL_ZERO;
    else if (sc_rd_hit && !we_i)
      sel_d = SEL_RAM;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= mode_i;
      mchg_q <= 1'b0;
      bank_q <= mode_mask(mode_i);
      sel_q  <= SEL_ZERO;
    end else begin
      mode_q <= mode_i;
      mchg_q <= (mode_i != mode_q);
      bank_q <= bank_d;
      sel_q  <= sel_d;
    end
  end

  // RAM keeps its contents across reset; reset only blocks the write.
  always_ff @(posedge clk_i) begin
    if (ram_we && rst_ni)
      ram_q[off[6:0]] <= dat_i;
    ram_rd_q <= ram_q[off[6:0]];
  end

  assign rom_full = (mode_q == 3'd0) ? {4'd0, off[10:0]}
                                     : {bank_q, off};
  assign rom_adr_o = rom_full[AW-1:0];
  assign bank_o    = bank_q;

  always_comb begin
    case (sel_q)
      SEL_ROM: dat_o = rom_dat_i;
      SEL_RAM: dat_o = ram_rd_q;
      default: dat_o = 8'h00;
    endcase
  end

endmodule

// File: doc/cart_mapper.md
CART_MAPPER -- requirements
Module: cart_mapper

Interface
REQ-001 SHALL have parameter MAX_BANKS, default 8, meaning the number of 4 KiB ROM banks supported; legal values are 1, 2, 4 or 8.
REQ-002 SHALL have parameter SC_EN, default 1, meaning Superchip 128-byte cartridge RAM is present (1) or absent (0).
REQ-003 SHALL have port clk_i, input, 1 bit: system clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1 bit: CPU access strobe, high for one clk_i per CPU cycle.
REQ-006 SHALL have port adr_i, input, 13 bits: CPU address A12..A0.
REQ-007 SHALL have port we_i, input, 1 bit: CPU write.
REQ-008 SHALL have port dat_i, input, 8 bits: CPU write data.
REQ-009 SHALL have port dat_o, output, 8 bits: cartridge read data.
REQ-010 SHALL have port mode_i, input, 3 bits: 0=2K, 1=4K, 2=F8, 3=F6, 4=F4, 5..7=4K.
REQ-011 SHALL have port sc_i, input, 1 bit: Superchip enable (ANDed with SC_EN).
REQ-012 SHALL have port rom_adr_o, output, 12+log2(MAX_BANKS) bits: address to the synchronous ROM.
REQ-013 SHALL have port rom_dat_i, input, 8 bits: ROM data, valid one clk_i after rom_adr_o.
REQ-014 SHALL have port bank_o, output, 3 bits: current bank, for diagnostics.

Function
REQ-015 Cart access SHALL be defined as adr_i[12]=1; offset = adr_i[11:0].
REQ-016 rom_adr_o SHALL be combinational {bank, offset}; in mode 2K, offset[11] SHALL be forced to 0 and bank SHALL be 0.
REQ-017 Bank count per mode: 2K/4K=1, F8=2, F6=4, F4=8; effective count = min(mode count, MAX_BANKS).
REQ-018 Start bank SHALL be the last effective bank (F8→1, F6→3, F4→7 when MAX_BANKS=8).
REQ-019 Hotspot ranges: F8 0xFF8-0xFF9; F6 0xFF6-0xFF9; F4 0xFF4-0xFFB.
REQ-020 On enable_i=1, cart access and offset in hotspot range, bank SHALL load (offset−base) masked to effective width, read or write alike.
REQ-021 A hotspot access SHALL itself be served from the old bank; the new bank SHALL apply from the next clk_i.
REQ-022 Accesses with enable_i=0 SHALL NOT change bank or write RAM.
REQ-023 mode_i SHALL be registered; when the registered value changes, bank SHALL reload the start bank of the new mode on the following clk_i, overriding a simultaneous hotspot.
REQ-024 With SC_EN·sc_i=1: writes SHALL hit offsets 0x000-0x07F, with RAM[offset[6:0]] <= dat_i on enable_i·we_i; reads SHALL hit 0x080-0x0FF, returning RAM[offset[6:0]].
REQ-025 A write to the Superchip read port SHALL be ignored; a read of the write port SHALL return ROM data without modifying RAM.
REQ-026 dat_o SHALL be registered with 1-clk_i latency: source select (ROM, SC RAM, or zero for non-cart) SHALL be captured with the address, and data SHALL be presented on the next clk_i.
REQ-027 Non-cart addresses SHALL yield dat_o=0x00 and SHALL have no side effects.
REQ-028 bank_o SHALL equal the bank register, zero-extended.

Reset
REQ-029 While rst_ni=0: bank SHALL be the start bank of the current mode_i, the registered mode SHALL be mode_i, the dat_o select SHALL be "zero", and dat_o SHALL be 0x00.
REQ-030 Reset mid-access SHALL abort any pending RAM write; SC RAM contents SHALL NOT be cleared.

Verification
REQ-031 Reset with mode_i=4 → bank_o=7; a read at 0x1000 → rom_adr_o=0x7000, dat_o=ROM[0x7000] one clk_i later.
REQ-032 mode_i=2, read 0x1FF8 → served from bank 1; next read 0x1000 → rom_adr_o=0x0000; write 0x1FF9 → bank_o=1.
REQ-033 mode_i=4 with MAX_BANKS=4, read 0x1FFB → bank_o=3 (masked).
REQ-034 SC on: write 0x1005=0xA5, read 0x1085 → dat_o=0xA5; write 0x1085=0x11 → a subsequent read still returns 0xA5.
REQ-035 mode_i changes from 3 to 2 on the same clk_i as a hotspot 0x1FF6 → bank_o=1 after two clk_i.
REQ-036 Access 0x0080 with enable_i=1 → dat_o=0x00 and bank unchanged; hotspot address with enable_i=0 → bank unchanged.
